// File: rtl/srambank_arbiter_2p.sv
// srambank_arbiter_2p: shares one 1-cycle-read SRAM bank between two
// single-beat requesters. Zero-fills the bank after reset (optional), then
// arbitrates round-robin and routes read data back to the owning port.
module srambank_arbiter_2p #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_write,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_data,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_write,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_data,
  output logic [ADDR_W-1:0] bank_address,
  output logic [DATA_W-1:0] bank_wd,
  output logic              bank_banksel,
  output logic              bank_read,
  output logic              bank_write,
  input  logic [DATA_W-1:0] bank_dataout,
  output logic              init_done
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam state_t            RST_STATE = INIT_EN ? S_INIT : S_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              rr;            // port favoured on the next conflict

  logic              gnt0_p0, gnt1_p0;
  logic              acc_p0, win_p0, wr_p0;
  logic              vld_p1, owner_p1;

  // ---- stage p0: arbitration and bank drive (combinational) ----

  // Round-robin grant; nothing is granted in INIT or while reset is held.
  always_comb begin
    gnt0_p0 = 1'b0;
    gnt1_p0 = 1'b0;
    if (!reset && state == S_RUN) begin
      if (p0_req_valid && p1_req_valid) begin
        gnt0_p0 = ~rr;
        gnt1_p0 = rr;
      end else begin
        gnt0_p0 = p0_req_valid;
        gnt1_p0 = p1_req_valid;
      end
    end
  end

  assign acc_p0       = gnt0_p0 | gnt1_p0;
  assign win_p0       = gnt1_p0;
  assign wr_p0        = win_p0 ? p1_req_write : p0_req_write;
  assign p0_req_ready = gnt0_p0;
  assign p1_req_ready = gnt1_p0;

  // Bank pins: zero-fill writes in INIT, the winner's op in RUN, idle otherwise.
  always_comb begin
    bank_banksel = 1'b0;
    bank_read    = 1'b0;
    bank_write   = 1'b0;
    bank_address = '0;
    bank_wd      = '0;
    if (!reset) begin
      if (state == S_INIT) begin
        bank_banksel = 1'b1;
        bank_write   = 1'b1;
        bank_address = cnt;
      end else if (acc_p0) begin
        bank_banksel = 1'b1;
        bank_read    = ~wr_p0;
        bank_write   = wr_p0;
        bank_address = win_p0 ? p1_req_addr  : p0_req_addr;
        bank_wd      = win_p0 ? p1_req_wdata : p0_req_wdata;
      end
    end
  end

  // Next state: INIT leaves for RUN after issuing the last fill write.
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && cnt == LAST_ADDR) begin
      state_nxt = S_RUN;
    end
  end

  // Control registers: FSM, fill counter, rr pointer, pending read tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RST_STATE;
      cnt      <= '0;
      rr       <= 1'b0;
      vld_p1   <= 1'b0;
      owner_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      if (state == S_INIT) begin
        cnt <= cnt + ADDR_W'(1);
      end
      if (acc_p0) begin
        rr <= ~win_p0;
      end
      vld_p1 <= acc_p0 & ~wr_p0;
      if (acc_p0 && !wr_p0) begin
        owner_p1 <= win_p0;
      end
    end
  end

  // ---- stage p1: read return, bank data lands one cycle after accept ----

  assign p0_rsp_valid = vld_p1 & ~owner_p1;
  assign p1_rsp_valid = vld_p1 & owner_p1;
  assign p0_rsp_data  = bank_dataout;
  assign p1_rsp_data  = bank_dataout;
  assign init_done    = ~reset & (state == S_RUN);

endmodule

// File: tb/tb_srambank_arbiter_2p.sv
// Bench for srambank_arbiter_2p: behavioural SRAM bank, zero-fill sequence,
// a vector table of request patterns scored through a response queue, and
// hand sequences for reset-during-read and the no-init configuration.
module tb_srambank_arbiter_2p;

  localparam logic [63:0] PAT = 64'hA5A5_5A5A_F0F0_0F0F;

  logic clk = 1'b0;
  logic rst, rst1, mdl_clr;
  always #5 clk = ~clk;

  // DUT with zero-fill
  logic        p0_req_valid, p0_req_ready, p0_req_write, p0_rsp_valid;
  logic [9:0]  p0_req_addr;
  logic [63:0] p0_req_wdata, p0_rsp_data;
  logic        p1_req_valid, p1_req_ready, p1_req_write, p1_rsp_valid;
  logic [9:0]  p1_req_addr;
  logic [63:0] p1_req_wdata, p1_rsp_data;
  logic [9:0]  bank_address;
  logic [63:0] bank_wd, bank_dataout;
  logic        bank_banksel, bank_read, bank_write, init_done;

  srambank_arbiter_2p #(.ADDR_W(10), .DATA_W(64), .DEPTH(1024), .INIT_EN(1'b1)) dut (
    .clk(clk), .reset(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
    .bank_address(bank_address), .bank_wd(bank_wd), .bank_banksel(bank_banksel),
    .bank_read(bank_read), .bank_write(bank_write), .bank_dataout(bank_dataout),
    .init_done(init_done)
  );

  // DUT without zero-fill
  logic        q0_valid, q0_ready, q0_write, q0_rsp_valid;
  logic [9:0]  q0_addr;
  logic [63:0] q0_wdata, q0_rsp_data;
  logic        q1_valid, q1_ready, q1_write, q1_rsp_valid;
  logic [9:0]  q1_addr;
  logic [63:0] q1_wdata, q1_rsp_data;
  logic [9:0]  b1_address;
  logic [63:0] b1_wd, b1_dataout;
  logic        b1_banksel, b1_read, b1_write, init_done1;

  srambank_arbiter_2p #(.ADDR_W(10), .DATA_W(64), .DEPTH(16), .INIT_EN(1'b0)) dut1 (
    .clk(clk), .reset(rst1),
    .p0_req_valid(q0_valid), .p0_req_ready(q0_ready), .p0_req_write(q0_write),
    .p0_req_addr(q0_addr), .p0_req_wdata(q0_wdata),
    .p0_rsp_valid(q0_rsp_valid), .p0_rsp_data(q0_rsp_data),
    .p1_req_valid(q1_valid), .p1_req_ready(q1_ready), .p1_req_write(q1_write),
    .p1_req_addr(q1_addr), .p1_req_wdata(q1_wdata),
    .p1_rsp_valid(q1_rsp_valid), .p1_rsp_data(q1_rsp_data),
    .bank_address(b1_address), .bank_wd(b1_wd), .bank_banksel(b1_banksel),
    .bank_read(b1_read), .bank_write(b1_write), .bank_dataout(b1_dataout),
    .init_done(init_done1)
  );

  // Behavioural bank: registered read; never-written words read back as PAT.
  logic [63:0] mem [0:1023];
  bit          wr_seen [0:1023];
  always @(posedge clk) begin
    if (mdl_clr) begin
      for (int i = 0; i < 1024; i++) wr_seen[i] <= 1'b0;
    end else if (bank_banksel) begin
      if (bank_write) begin
        mem[bank_address]     <= bank_wd;
        wr_seen[bank_address] <= 1'b1;
      end
      if (bank_read) bank_dataout <= wr_seen[bank_address] ? mem[bank_address] : PAT;
    end
  end
  assign b1_dataout = 64'h0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic v0, w0; logic [9:0] a0; logic [63:0] d0;
    logic v1, w1; logic [9:0] a1; logic [63:0] d1;
    logic r0, r1;
  } vec_t;

  typedef struct {
    int          due;
    logic        port;
    logic [63:0] data;
  } exp_t;

  vec_t        tbl [18];
  exp_t        sbq [$];
  logic [63:0] shadow [0:1023];

  function automatic vec_t mk(input logic v0, input logic w0, input logic [9:0] a0,
                              input logic [63:0] d0, input logic v1, input logic w1,
                              input logic [9:0] a1, input logic [63:0] d1,
                              input logic r0, input logic r1);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  // One table row: drive after the edge, score responses/grants/pins mid-cycle.
  task automatic apply(input vec_t v, input int idx);
    logic        ev0, ev1, eb, ew;
    logic [9:0]  ea;
    logic [63:0] ed, edat;
    exp_t        e;
    @(posedge clk); #1;
    cyc++;
    p0_req_valid = v.v0; p0_req_write = v.w0; p0_req_addr = v.a0; p0_req_wdata = v.d0;
    p1_req_valid = v.v1; p1_req_write = v.w1; p1_req_addr = v.a1; p1_req_wdata = v.d1;
    @(negedge clk);
    ev0 = 1'b0; ev1 = 1'b0; edat = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      ev0 = ~e.port; ev1 = e.port; edat = e.data;
    end
    chk($sformatf("rsp_valid[%0d]", idx), 128'({p0_rsp_valid, p1_rsp_valid}), 128'({ev0, ev1}));
    if (ev0) chk($sformatf("p0_rsp_data[%0d]", idx), 128'(p0_rsp_data), 128'(edat));
    if (ev1) chk($sformatf("p1_rsp_data[%0d]", idx), 128'(p1_rsp_data), 128'(edat));
    chk($sformatf("ready[%0d]", idx), 128'({p0_req_ready, p1_req_ready}), 128'({v.r0, v.r1}));
    eb = v.r0 | v.r1; ew = 1'b0; ea = '0; ed = '0;
    if (v.r0) begin ew = v.w0; ea = v.a0; ed = v.d0; end
    else if (v.r1) begin ew = v.w1; ea = v.a1; ed = v.d1; end
    chk($sformatf("bank[%0d]", idx),
        128'({bank_banksel, bank_read, bank_write, bank_address, bank_wd}),
        128'({eb, eb & ~ew, eb & ew, ea, ed}));
    if (eb) begin
      if (ew) shadow[ea] = ed;
      else begin
        e.due = cyc + 1; e.port = v.r1; e.data = shadow[ea];
        sbq.push_back(e);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ibad, zbad;
    rst = 1'b1; rst1 = 1'b1; mdl_clr = 1'b1;
    p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 10'h3FF; p0_req_wdata = 64'h11;
    p1_req_valid = 1'b1; p1_req_write = 1'b1; p1_req_addr = 10'h005; p1_req_wdata = 64'h22;
    q0_valid = 1'b1; q0_write = 1'b0; q0_addr = 10'h005; q0_wdata = '0;
    q1_valid = 1'b0; q1_write = 1'b0; q1_addr = '0;     q1_wdata = '0;

    tbl[0]  = mk(1, 0, 10'h3FF, 64'h0,                   0, 0, 10'h000, 64'h0, 1, 0);
    tbl[1]  = mk(1, 1, 10'h010, 64'hDEADBEEF_CAFEF00D,   0, 0, 10'h000, 64'h0, 1, 0);
    tbl[2]  = mk(0, 0, 10'h000, 64'h0,                   1, 0, 10'h010, 64'h0, 0, 1);
    tbl[3]  = mk(1, 1, 10'h001, 64'h0000_0000_0000_00A1, 1, 1, 10'h002, 64'hB2, 1, 0);
    tbl[4]  = mk(0, 0, 10'h000, 64'h0,                   1, 1, 10'h002, 64'hB2, 0, 1);
    tbl[5]  = mk(1, 0, 10'h001, 64'h0,                   1, 0, 10'h002, 64'h0, 1, 0);
    tbl[6]  = mk(1, 0, 10'h001, 64'h0,                   1, 0, 10'h002, 64'h0, 0, 1);
    tbl[7]  = mk(1, 0, 10'h001, 64'h0,                   1, 0, 10'h002, 64'h0, 1, 0);
    tbl[8]  = mk(1, 0, 10'h001, 64'h0,                   1, 0, 10'h002, 64'h0, 0, 1);
    tbl[9]  = mk(1, 0, 10'h001, 64'h0,                   1, 0, 10'h002, 64'h0, 1, 0);
    tbl[10] = mk(1, 0, 10'h001, 64'h0,                   1, 0, 10'h002, 64'h0, 0, 1);
    tbl[11] = mk(1, 1, 10'h020, 64'h5,                   1, 0, 10'h020, 64'h0, 1, 0);
    tbl[12] = mk(0, 0, 10'h000, 64'h0,                   1, 0, 10'h020, 64'h0, 0, 1);
    tbl[13] = mk(0, 0, 10'h000, 64'h0,                   0, 0, 10'h000, 64'h0, 0, 0);
    tbl[14] = mk(1, 0, 10'h030, 64'h0,                   0, 0, 10'h000, 64'h0, 1, 0);
    tbl[15] = mk(1, 0, 10'h020, 64'h0,                   1, 1, 10'h020, 64'h7, 0, 1);
    tbl[16] = mk(1, 0, 10'h020, 64'h0,                   0, 0, 10'h000, 64'h0, 1, 0);
    tbl[17] = mk(0, 0, 10'h000, 64'h0,                   0, 0, 10'h000, 64'h0, 0, 0);

    repeat (2) @(posedge clk);
    #1 mdl_clr = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", 128'({p0_req_ready, p1_req_ready, init_done, p0_rsp_valid, p1_rsp_valid}), 128'(0));
    chk("reset_bank", 128'({bank_banksel, bank_read, bank_write, bank_address, bank_wd}), 128'(0));
    chk("reset_ctrl_noinit", 128'({q0_ready, q1_ready, init_done1, b1_banksel, b1_read, b1_write}), 128'(0));

    // No-init configuration: live in the first cycle after reset release.
    @(posedge clk); #1 rst1 = 1'b0;
    @(negedge clk);
    chk("noinit_ready", 128'({init_done1, q0_ready, q1_ready}), 128'(3'b110));
    chk("noinit_bank", 128'({b1_banksel, b1_read, b1_write, b1_address}), 128'({3'b110, 10'h005}));
    @(posedge clk); #1 q0_valid = 1'b0;
    @(negedge clk);
    chk("noinit_rsp", 128'({q0_rsp_valid, q1_rsp_valid, b1_write}), 128'(3'b100));

    // Zero-fill: exactly 1024 writes to 0..1023 with requests ignored.
    @(posedge clk); #1 rst = 1'b0;
    ibad = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if ({bank_banksel, bank_write, bank_read, bank_address, bank_wd, init_done,
           p0_req_ready, p1_req_ready} !== {3'b110, 10'(i), 64'h0, 3'b000}) begin
        if (ibad < 4) $display("init cycle %0d: addr=%h sel=%b wr=%b rd=%b done=%b", i,
                               bank_address, bank_banksel, bank_write, bank_read, init_done);
        ibad++;
      end
      if (i == 1023) begin
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
      end
    end
    chk("init_sequence_bad_cycles", 128'(ibad), 128'(0));
    @(negedge clk);
    chk("init_done_1025", 128'({init_done, bank_banksel, bank_write, p0_req_ready, p1_req_ready}),
        128'(5'b10000));
    zbad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!wr_seen[i] || mem[i] !== 64'h0) zbad++;
      shadow[i] = 64'h0;
    end
    chk("zero_fill_words_bad", 128'(zbad), 128'(0));

    // Table of request patterns, responses scored through the queue.
    for (int k = 0; k < 18; k++) apply(tbl[k], k);
    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));

    // Reset right after a read is accepted: response dropped, bank idle, INIT restarts.
    @(posedge clk); #1;
    p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 10'h010;
    @(negedge clk);
    chk("pre_reset_grant", 128'({p0_req_ready, bank_read}), 128'(2'b11));
    @(posedge clk); #1;
    rst = 1'b1; p0_req_valid = 1'b0;
    @(negedge clk);
    chk("midreset_rsp", 128'({p0_rsp_valid, p1_rsp_valid, init_done}), 128'(0));
    chk("midreset_bank", 128'({bank_banksel, bank_read, bank_write, bank_address, bank_wd}), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reinit_first", 128'({bank_banksel, bank_write, bank_read, bank_address, p0_rsp_valid, init_done}),
        128'({3'b110, 10'h000, 2'b00}));
    @(negedge clk);
    chk("reinit_second", 128'({bank_banksel, bank_write, bank_address}), 128'({2'b11, 10'h001}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
